thermometer_serial_decoder: RTL and testbench

Sequential receive-side counterpart to the thermometer encoder. It accepts a W-bit thermometer code one bit per handshake, LSB first, and reassembles the frame. It then reports the binary value (count of ones) plus a monotonicity error flag over a valid/ready output handshake. It sits between a bit-serial source (switch stepper or serializer) and the LED display logic.

---
 rtl/thermometer_serial_decoder.sv | 121 ++++++++++++
 tb/tb_thermometer_serial_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/thermometer_serial_decoder.sv
//==============================================================================
// Module   : thermometer_serial_decoder
// Purpose  : Bit-serial (LSB first) thermometer frame receiver reporting the
//            ones count, a monotonicity error flag and the raw frame.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module thermometer_serial_decoder #(
    parameter int K = 3,
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_bit,
    output logic         in_ready,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] q,
    output logic         err,
    output logic [W-1:0] code
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(W - 1);

    typedef enum logic [0:0] {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [K-1:0]     r_ones;
    logic             r_seen0;
    logic             r_err_acc;
    logic [K-1:0]     r_q;
    logic             r_err;
    logic [W-1:0]     r_code;

    logic             w_accept;
    logic             w_last;
    logic             w_release;
    logic [K-1:0]     w_ones_next;
    logic             w_err_next;

    // Handshake outputs come straight from the state register only.
    assign in_ready  = (r_state == RECV);
    assign out_valid = (r_state == HOLD);
    assign q         = r_q;
    assign err       = r_err;
    assign code      = r_code;

    assign w_accept    = in_valid && (r_state == RECV);
    assign w_last      = w_accept && (r_idx == C_LAST_IDX);
    assign w_release   = (r_state == HOLD) && out_ready;
    assign w_ones_next = r_ones + K'(in_bit);
    assign w_err_next  = r_err_acc | (r_seen0 & in_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RECV;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = RECV;
        end else begin
            case (r_state)
                RECV:    if (w_last)    w_state_next = HOLD;
                HOLD:    if (w_release) w_state_next = RECV;
                default: w_state_next = RECV;
            endcase
        end
    end

    // A 1 arriving after any 0 breaks monotonicity; the current bit is folded
    // into the latched results so the last bit counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_ones    <= '0;
            r_seen0   <= 1'b0;
            r_err_acc <= 1'b0;
            r_q       <= '0;
            r_err     <= 1'b0;
            r_code    <= '0;
        end else if (abort) begin
            r_idx     <= '0;
            r_ones    <= '0;
            r_seen0   <= 1'b0;
            r_err_acc <= 1'b0;
        end else if (w_accept) begin
            r_code[r_idx] <= in_bit;
            r_ones        <= w_ones_next;
            r_seen0       <= r_seen0 | ~in_bit;
            r_err_acc     <= w_err_next;
            if (w_last) begin
                r_q   <= w_ones_next;
                r_err <= w_err_next;
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end else if (w_release) begin
            r_ones    <= '0;
            r_seen0   <= 1'b0;
            r_err_acc <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_thermometer_serial_decoder.sv
//==============================================================================
// Module   : tb_thermometer_serial_decoder
// Purpose  : Directed self-checking bench with a frame-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_thermometer_serial_decoder;

    localparam int K = 3;
    localparam int W = 7;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_bit;
    logic         in_ready;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] q;
    logic         err;
    logic [W-1:0] code;

    int n_checks;
    int n_pass;

    thermometer_serial_decoder #(.K(K), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .err       (err),
        .code      (code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level reference: results are computed from the whole frame
    // (population count, "any 1 above a 0"), not from running accumulators.
    function automatic logic [W-1:0] with_bit(input logic [W-1:0] f, input int i, input logic b);
        logic [W-1:0] r;
        r    = f;
        r[i] = b;
        return r;
    endfunction

    function automatic int count_ones(input logic [W-1:0] f);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) n += int'(f[i]);
        return n;
    endfunction

    function automatic logic is_illegal(input logic [W-1:0] f);
        for (int i = 0; i < W; i++)
            for (int j = i + 1; j < W; j++)
                if (!f[i] && f[j]) return 1'b1;
        return 1'b0;
    endfunction

    logic         m_hold;
    int           m_n;
    int           m_q;
    logic         m_err;
    logic [W-1:0] m_code;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold <= 1'b0;
            m_n    <= 0;
            m_q    <= 0;
            m_err  <= 1'b0;
            m_code <= '0;
        end else if (abort) begin
            m_hold <= 1'b0;
            m_n    <= 0;
        end else if (m_hold) begin
            if (out_ready) m_hold <= 1'b0;
        end else if (in_valid) begin
            m_code <= with_bit(m_code, m_n, in_bit);
            if (m_n == W - 1) begin
                m_q    <= count_ones(with_bit(m_code, m_n, in_bit));
                m_err  <= is_illegal(with_bit(m_code, m_n, in_bit));
                m_hold <= 1'b1;
                m_n    <= 0;
            end else begin
                m_n <= m_n + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic compare_model();
        check("model in_ready",  int'(in_ready),  int'(!m_hold));
        check("model out_valid", int'(out_valid), int'(m_hold));
        check("model q",         int'(q),         m_q);
        check("model err",       int'(err),       int'(m_err));
        check("model code",      int'(code),      int'(m_code));
    endtask

    // One cycle: drive after the edge, compare on the falling edge, then
    // let the rising edge consume the inputs.
    task automatic step(input logic v, input logic b, input logic ab, input logic rdy);
        in_valid  = v;
        in_bit    = b;
        abort     = ab;
        out_ready = rdy;
        @(negedge clk);
        compare_model();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [W-1:0] f, input int nbits, input int maxgap);
        for (int i = 0; i < nbits; i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int g = 0; g < gap; g++) step(1'b0, 1'(($urandom_range(0, 1))), 1'b0, 1'b0);
            step(1'b1, f[i], 1'b0, 1'b0);
        end
    endtask

    task automatic expect_frame(input string name, input int eq, input int eerr, input int ecode);
        check({name, " out_valid"}, int'(out_valid), 1);
        check({name, " q"},         int'(q),         eq);
        check({name, " err"},       int'(err),       eerr);
        check({name, " code"},      int'(code),      ecode);
    endtask

    task automatic consume();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("after consume out_valid", int'(out_valid), 0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready",  int'(in_ready),  1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset q",         int'(q),         0);
        check("reset err",       int'(err),       0);
        check("reset code",      int'(code),      0);
        rst_n = 1'b1;

        // Legal frame with continuous in_valid; completion visible right after bit 6
        send_bits(7'b0000111, W, 0);
        expect_frame("legal3", 3, 0, 7'b0000111);
        consume();

        send_bits(7'b0000000, W, 0);
        expect_frame("zeros", 0, 0, 7'b0000000);
        consume();

        send_bits(7'b1111111, W, 0);
        expect_frame("ones", 7, 0, 7'h7F);
        consume();

        // Bits 1,0,1,1,0,0,1 (bit 0 first)
        send_bits(7'b1001101, W, 0);
        expect_frame("illegal", 4, 1, 7'b1001101);
        consume();

        send_bits(7'b0000001, W, 0);
        expect_frame("err cleared", 1, 0, 7'b0000001);

        // Backpressure: bits offered while held must be ignored
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'(($urandom_range(0, 1))), 1'b0, 1'b0);
            check("bp in_ready", int'(in_ready), 0);
        end
        expect_frame("bp stable", 1, 0, 7'b0000001);
        consume();

        // Bits 1,1,1,1,1,0,0 with random idle gaps
        send_bits(7'b0011111, W, 4);
        expect_frame("gaps", 5, 0, 7'b0011111);
        consume();

        // Abort after 3 bits, then a clean frame
        send_bits(7'b1111111, 3, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(7'b0000011, W, 0);
        expect_frame("after abort", 2, 0, 7'b0000011);

        // Abort in HOLD discards the held frame but keeps q/err/code
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("abort hold out_valid", int'(out_valid), 0);
        check("abort hold q", int'(q), 2);

        // Abort beats a completing bit
        send_bits(7'b0111111, W - 1, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("abort last out_valid", int'(out_valid), 0);
        send_bits(7'b0001111, W, 0);
        expect_frame("after abort last", 4, 0, 7'b0001111);
        consume();

        // Asynchronous reset mid-frame, off the clock edge
        send_bits(7'b1111111, 3, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst in_ready",  int'(in_ready),  1);
        check("async rst out_valid", int'(out_valid), 0);
        check("async rst q",         int'(q),         0);
        check("async rst err",       int'(err),       0);
        check("async rst code",      int'(code),      0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_bits(7'b0000111, W, 0);
        expect_frame("after rst", 3, 0, 7'b0000111);
        consume();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
